pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-issue CPU; successor to the basic PC register.
- Generates the fetch PC with:
  - sequential advance bounded by a limit
  - branch redirect
  - call/return through a circular return-address stack (RAS)
  - trap entry/exit with a saved exception PC
- Feeds instruction fetch; control inputs come from decode/execute and the hazard unit.

Parameters:
- ADDR_W, 32: PC/address width in bits.
- RESET_VEC, 0: PC value after reset or while not inited.
- PC_LIMIT, 65536: sequential advance stops once pc >= PC_LIMIT.
- TRAP_VEC, 32'h0000_FF00: trap handler entry address.
- RAS_DEPTH, 4: RAS entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- inited  in  1  0 = hold PC at RESET_VEC (program load in progress).
- stall  in  1  freeze PC, RAS and trap state (trap excepted, see below).
- branch_flag  in  1  take branch this cycle.
- branch_addr  in  ADDR_W  branch target.
- call_flag  in  1  call: redirect and push return address.
- call_addr  in  ADDR_W  call target.
- ret_flag  in  1  return: pop RAS.
- trap_flag  in  1  trap request.
- eret_flag  in  1  return from trap.
- pc  out  ADDR_W  current fetch PC.
- epc  out  ADDR_W  PC saved at trap entry.
- in_trap  out  1  inside trap handler.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset (rst=0 at posedge):
  - pc=RESET_VEC, epc=0, in_trap=0
  - RAS count=0, pointer=0, ras_empty=1, ras_full=0, ras_err=0
  - Reset overrides every other input.
- inited=0 (rst=1): same clearing as reset, except ras_err is retained.
- Arithmetic: all sums are modulo 2^ADDR_W. Bits [1:0] of branch_addr and call_addr are forced to 0. pc4 = pc+4.
- Priority per cycle, applied when rst=1 and inited=1; exactly one action:
  1. trap_flag (acts even if stall=1): epc<=pc, pc<=TRAP_VEC, in_trap<=1. A trap while in_trap=1 re-enters: epc is overwritten.
  2. stall=1: hold all state.
  3. eret_flag with in_trap=1: pc<=epc+4, in_trap<=0. eret with in_trap=0 falls through to the lower-priority actions.
  4. branch_flag: pc<=branch_addr.
  5. ret_flag:
     - RAS non-empty: pc<=top entry, count-1.
     - RAS empty: pc<=pc4 (if pc<PC_LIMIT, else hold), ras_err<=1.
  6. call_flag: pc<=call_addr; push pc4.
     - RAS full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_err<=1.
  7. Otherwise: pc<=pc4 if pc<PC_LIMIT, else hold pc. pc may therefore equal PC_LIMIT, then stops.
- Simultaneous ret+call: ret wins; no push.
- Latency: all outputs are registered and change one cycle after the qualifying edge. There is no combinational path from inputs to outputs.
- RAS:
  - Storage is RAS_DEPTH x ADDR_W with a wrapping log2(RAS_DEPTH)-bit top pointer and a 0..RAS_DEPTH count.
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
  - Entries are not cleared on pop.

Test Plan:
- Reset/init: rst=0 for 2 cycles, then rst=1 with inited=0 for 3 cycles, then inited=1 → pc=0 throughout, then 4, 8, 12 on successive cycles; ras_empty=1.
- Limit: PC_LIMIT=16, run 8 cycles → pc sequence 4, 8, 12, 16, 16, 16...; branch_addr=32'h6 at pc=16 → pc=4.
- Call/return nesting: from pc=0x20, call 0x100, then next cycle call 0x200, then ret, then ret → pc=0x100, 0x200, 0x104, 0x24; ras_empty=1; ras_err=0.
- RAS overflow/underflow (depth 4):
  - 5 calls from distinct PCs, then 4 rets → returns are the last four pushed, LIFO; ras_err=1.
  - A fifth ret → pc advances by 4.
- Trap under stall: pc=0x40, stall=1 and trap_flag=1 → pc=0xFF00, epc=0x40, in_trap=1. eret → pc=0x44, in_trap=0. eret with in_trap=0 → pc+4.
- Priority: trap+branch+call same cycle → trap taken, no push. branch+ret same cycle → branch taken, RAS count unchanged.

Source files
------------

// File: rtl/pc_unit_if.sv
// PC unit control/status bundle.
// Master drives decode/hazard controls, slave returns fetch PC state.
interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              inited;
  logic              stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_addr;
  logic              call_flag;
  logic [ADDR_W-1:0] call_addr;
  logic              ret_flag;
  logic              trap_flag;
  logic              eret_flag;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] epc;
  logic              in_trap;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output inited, stall,
    output branch_flag, branch_addr,
    output call_flag, call_addr,
    output ret_flag, trap_flag, eret_flag,
    input  pc, epc, in_trap,
    input  ras_empty, ras_full, ras_err
  );

  modport slave (
    input  inited, stall,
    input  branch_flag, branch_addr,
    input  call_flag, call_addr,
    input  ret_flag, trap_flag, eret_flag,
    output pc, epc, in_trap,
    output ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC generator: bounded sequential advance, branch,
// call/return via circular RAS, trap entry/exit.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter longint            PC_LIMIT  = 65536,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = 'h0000_FF00,
  parameter int                RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LIM  = ADDR_W'(PC_LIMIT);
  localparam logic [CW-1:0]     FULL = CW'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] epc_q;
  logic              trap_q;
  logic              err_q;
  logic [PW-1:0]     top_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_t;
  logic [ADDR_W-1:0] call_t;

  assign pc4    = pc_q + FOUR;
  assign seq_pc = (pc_q < LIM) ? pc4 : pc_q;
  assign br_t   = {bus.branch_addr[ADDR_W-1:2], 2'b00};
  assign call_t = {bus.call_addr[ADDR_W-1:2], 2'b00};

  logic do_trap;
  logic do_hold;
  logic do_eret;
  logic do_br;
  logic do_ret;
  logic do_call;

  // One-hot action select; plain sequential advance is the fallback.
  always_comb begin
    do_trap = 1'b0;
    do_hold = 1'b0;
    do_eret = 1'b0;
    do_br   = 1'b0;
    do_ret  = 1'b0;
    do_call = 1'b0;
    if (bus.trap_flag)                do_trap = 1'b1;
    else if (bus.stall)               do_hold = 1'b1;
    else if (bus.eret_flag && trap_q) do_eret = 1'b1;
    else if (bus.branch_flag)         do_br   = 1'b1;
    else if (bus.ret_flag)            do_ret  = 1'b1;
    else if (bus.call_flag)           do_call = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      trap_q <= 1'b0;
      top_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (!bus.inited) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      trap_q <= 1'b0;
      top_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (1'b1)
        do_trap: begin
          epc_q  <= pc_q;
          pc_q   <= TRAP_VEC;
          trap_q <= 1'b1;
        end
        do_hold: ;
        do_eret: begin
          pc_q   <= epc_q + FOUR;
          trap_q <= 1'b0;
        end
        do_br: pc_q <= br_t;
        do_ret: begin
          if (cnt_q != '0) begin
            pc_q  <= ras_q[top_q];
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            pc_q  <= seq_pc;
            err_q <= 1'b1;
          end
        end
        do_call: begin
          // A full stack wraps onto its oldest slot.
          pc_q <= call_t;
          ras_q[top_q + 1'b1] <= pc4;
          top_q <= top_q + 1'b1;
          if (cnt_q == FULL) err_q <= 1'b1;
          else               cnt_q <= cnt_q + 1'b1;
        end
        default: pc_q <= seq_pc;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.in_trap   = trap_q;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == FULL);
  assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic,
// two instances (default limit and limit 16) against a reference model.
module tb_pc_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inited;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        call_flag;
  logic [31:0] call_addr;
  logic        ret_flag;
  logic        trap_flag;
  logic        eret_flag;

  pc_unit_if #(.ADDR_W(32)) ia ();
  pc_unit_if #(.ADDR_W(32)) ib ();

  assign ia.inited      = inited;
  assign ia.stall       = stall;
  assign ia.branch_flag = branch_flag;
  assign ia.branch_addr = branch_addr;
  assign ia.call_flag   = call_flag;
  assign ia.call_addr   = call_addr;
  assign ia.ret_flag    = ret_flag;
  assign ia.trap_flag   = trap_flag;
  assign ia.eret_flag   = eret_flag;

  assign ib.inited      = inited;
  assign ib.stall       = stall;
  assign ib.branch_flag = branch_flag;
  assign ib.branch_addr = branch_addr;
  assign ib.call_flag   = call_flag;
  assign ib.call_addr   = call_addr;
  assign ib.ret_flag    = ret_flag;
  assign ib.trap_flag   = trap_flag;
  assign ib.eret_flag   = eret_flag;

  pc_unit u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  pc_unit #(.PC_LIMIT(16)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: stack kept as a plain bounded list, oldest at index 0.
  logic [31:0] m_pc  [2];
  logic [31:0] m_epc [2];
  logic        m_trap[2];
  logic        m_err [2];
  int          m_sz  [2];
  logic [31:0] m_stk [2][4];
  logic [31:0] lim   [2] = '{32'd65536, 32'd16};

  function automatic logic [31:0] nxt(input int k);
    return (m_pc[k] < lim[k]) ? m_pc[k] + 32'd4 : m_pc[k];
  endfunction

  task automatic push(input int k, input logic [31:0] v);
    if (m_sz[k] == 4) begin
      for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
      m_stk[k][3] = v;
      m_err[k] = 1'b1;
    end else begin
      m_stk[k][m_sz[k]] = v;
      m_sz[k]++;
    end
  endtask

  task automatic step(input int k);
    if (!rst || !inited) begin
      m_pc[k] = 32'd0; m_epc[k] = 32'd0;
      m_trap[k] = 1'b0; m_sz[k] = 0;
      if (!rst) m_err[k] = 1'b0;
    end else if (trap_flag) begin
      m_epc[k] = m_pc[k]; m_pc[k] = 32'h0000_FF00; m_trap[k] = 1'b1;
    end else if (stall) begin
    end else if (eret_flag && m_trap[k]) begin
      m_pc[k] = m_epc[k] + 32'd4; m_trap[k] = 1'b0;
    end else if (branch_flag) begin
      m_pc[k] = branch_addr & ~32'd3;
    end else if (ret_flag) begin
      if (m_sz[k] > 0) begin
        m_sz[k]--; m_pc[k] = m_stk[k][m_sz[k]];
      end else begin
        m_err[k] = 1'b1; m_pc[k] = nxt(k);
      end
    end else if (call_flag) begin
      push(k, m_pc[k] + 32'd4);
      m_pc[k] = call_addr & ~32'd3;
    end else begin
      m_pc[k] = nxt(k);
    end
  endtask

  task automatic cmp_all();
    chk("a.pc",    ia.pc,        m_pc[0]);
    chk("a.epc",   ia.epc,       m_epc[0]);
    chk("a.trap",  32'(ia.in_trap),   32'(m_trap[0]));
    chk("a.empty", 32'(ia.ras_empty), 32'(m_sz[0] == 0));
    chk("a.full",  32'(ia.ras_full),  32'(m_sz[0] == 4));
    chk("a.err",   32'(ia.ras_err),   32'(m_err[0]));
    chk("b.pc",    ib.pc,        m_pc[1]);
    chk("b.epc",   ib.epc,       m_epc[1]);
    chk("b.trap",  32'(ib.in_trap),   32'(m_trap[1]));
    chk("b.empty", 32'(ib.ras_empty), 32'(m_sz[1] == 0));
    chk("b.full",  32'(ib.ras_full),  32'(m_sz[1] == 4));
    chk("b.err",   32'(ib.ras_err),   32'(m_err[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    stall = 0; branch_flag = 0; call_flag = 0;
    ret_flag = 0; trap_flag = 0; eret_flag = 0;
    branch_addr = 0; call_addr = 0;
  endtask

  logic [31:0] tgt [5] = '{32'h4, 32'h30, 32'h40, 32'h50, 32'h60};
  logic [31:0] rets[4] = '{32'h54, 32'h44, 32'h34, 32'h8};

  initial begin
    idle();
    rst = 0; inited = 0;
    tick(); tick();
    chk("rst.pc", ia.pc, 32'h0);
    chk("rst.empty", 32'(ia.ras_empty), 32'h1);
    rst = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("init.pc", ia.pc, 32'h0);
    inited = 1;
    tick(); chk("seq.4", ia.pc, 32'h4);
    tick(); chk("seq.8", ia.pc, 32'h8);
    tick(); chk("seq.12", ia.pc, 32'hC);
    for (int i = 0; i < 5; i++) tick();
    chk("lim.hold", ib.pc, 32'h10);
    chk("nolim.pc", ia.pc, 32'h20);
    branch_flag = 1; branch_addr = 32'h6;
    tick(); chk("br.align", ib.pc, 32'h4);

    branch_addr = 32'h20; tick();
    branch_flag = 0;
    call_flag = 1; call_addr = 32'h100;
    tick(); chk("call1", ia.pc, 32'h100);
    call_addr = 32'h200;
    tick(); chk("call2", ia.pc, 32'h200);
    call_flag = 0; ret_flag = 1;
    tick(); chk("ret1", ia.pc, 32'h104);
    tick(); chk("ret2", ia.pc, 32'h24);
    ret_flag = 0;
    chk("nest.empty", 32'(ia.ras_empty), 32'h1);
    chk("nest.err", 32'(ia.ras_err), 32'h0);

    branch_flag = 1; branch_addr = 32'h0; tick();
    branch_flag = 0; call_flag = 1;
    for (int i = 0; i < 5; i++) begin
      call_addr = tgt[i];
      tick();
      if (i == 3) chk("ovf.full", 32'(ia.ras_full), 32'h1);
    end
    call_flag = 0; ret_flag = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("ovf.ret", ia.pc, rets[i]);
    end
    chk("ovf.err", 32'(ia.ras_err), 32'h1);
    tick(); chk("unf.pc", ia.pc, 32'hC);
    ret_flag = 0;

    branch_flag = 1; branch_addr = 32'h40; tick();
    branch_flag = 0; stall = 1; trap_flag = 1;
    tick();
    chk("trap.pc", ia.pc, 32'hFF00);
    chk("trap.epc", ia.epc, 32'h40);
    chk("trap.in", 32'(ia.in_trap), 32'h1);
    stall = 0; trap_flag = 0; eret_flag = 1;
    tick(); chk("eret.pc", ia.pc, 32'h44);
    tick(); chk("eret.fall", ia.pc, 32'h48);
    eret_flag = 0;

    trap_flag = 1; branch_flag = 1; call_flag = 1;
    branch_addr = 32'h300; call_addr = 32'h400;
    tick();
    chk("pri.trap", ia.pc, 32'hFF00);
    chk("pri.nopush", 32'(ia.ras_empty), 32'h1);
    idle(); eret_flag = 1; tick();
    eret_flag = 0; call_flag = 1; call_addr = 32'h80; tick();
    call_flag = 0; branch_flag = 1; branch_addr = 32'h90; ret_flag = 1;
    tick();
    chk("pri.br", ia.pc, 32'h90);
    chk("pri.keep", 32'(ia.ras_empty), 32'h0);
    idle();

    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom % 64) != 0;
      inited      = ($urandom % 32) != 0;
      stall       = ($urandom % 8) == 0;
      branch_flag = ($urandom % 5) == 0;
      call_flag   = ($urandom % 3) == 0;
      ret_flag    = ($urandom % 4) == 0;
      trap_flag   = ($urandom % 16) == 0;
      eret_flag   = ($urandom % 6) == 0;
      branch_addr = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 63);
      call_addr   = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 63);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
